mac_dot_sequencer: RTL
======================

MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum cycles spent waiting for a MAC result.
REQ-002 Port aclk, input, 1, clock; all logic on its rising edge.
REQ-003 Port aresetn, input, 1, reset: synchronous, active-low.
REQ-004 Port s_axis_tvalid, input, 1, operand pair valid.
REQ-005 Port s_axis_tready, output, 1, operand pair accepted when high with tvalid.
REQ-006 Port s_axis_tdata, input, 16, {b[7:0], a[7:0]} unsigned operand pair.
REQ-007 Port s_axis_tlast, input, 1, marks final pair of a dot product.
REQ-008 Ports mac_a_tvalid/mac_b_tvalid/mac_c_tvalid, output, 1 each, MAC operand valids.
REQ-009 Ports mac_a_tdata (8), mac_b_tdata (8), mac_c_tdata (32), output, MAC operands a, b and accumulator-in.
REQ-010 Ports mac_result_tvalid (1) and mac_result_tdata (32), input, MAC result, one cycle after operands are presented.
REQ-011 Port m_axis_tvalid, output, 1, dot-product result valid.
REQ-012 Port m_axis_tready, input, 1, downstream accept.
REQ-013 Port m_axis_tdata, output, 32, accumulated dot product.
REQ-014 Port m_axis_tuser, output, 17, {timeout_err, element_count[15:0]}.

Function
REQ-015 The FSM SHALL have states ACCEPT, ISSUE, WAIT, OUTPUT; reset state ACCEPT.
REQ-016 s_axis_tready SHALL be high only in ACCEPT; all other outputs SHALL be registered.
REQ-017 ACCEPT: on s_axis handshake, the block SHALL latch a, b, tlast, drive mac_c_tdata = acc, and go to ISSUE.
REQ-018 ISSUE: all three mac_*_tvalid SHALL be high for exactly this one cycle; the next state is WAIT with the wait counter cleared.
REQ-019 mac_*_tvalid SHALL be low in every state other than ISSUE; mac_*_tdata SHALL hold their last values.
REQ-020 WAIT: on mac_result_tvalid, acc SHALL load mac_result_tdata and element_count SHALL increment, saturating at 0xFFFF.
REQ-021 After a WAIT capture, the next state SHALL be OUTPUT if the latched tlast = 1, else ACCEPT.
REQ-022 mac_result_tvalid outside WAIT SHALL be ignored.
REQ-023 WAIT timeout: if no result arrives within TIMEOUT cycles, timeout_err SHALL be set, acc SHALL be unchanged, and the next state SHALL be OUTPUT regardless of tlast.
REQ-024 After a timeout, OUTPUT SHALL behave as in REQ-025 with the current acc.
REQ-025 OUTPUT: m_axis_tvalid = 1 with m_axis_tdata = acc and m_axis_tuser = {timeout_err, element_count}, held stable until m_axis_tready.
REQ-026 On an OUTPUT handshake, acc, element_count and timeout_err SHALL clear and the next state SHALL be ACCEPT; the first handshake is possible in the cycle after OUTPUT is entered.
REQ-027 Arithmetic SHALL be performed by the MAC only; the block SHALL NOT modify result data (MAC result = ((a*b)>>2) + c, 32-bit wrap).
REQ-028 Throughput SHALL be 1 pair per 3 cycles with no stalls.
REQ-029 s_axis_tvalid dropping without a handshake SHALL have no effect.

Reset
REQ-030 When aresetn = 0 at a clock edge, the next state SHALL be ACCEPT.
REQ-031 Reset values: acc = 0, element_count = 0, timeout_err = 0, wait counter = 0.
REQ-032 Reset output values: s_axis_tready = 0 during reset and 1 after the first edge with aresetn = 1; all mac_*_tvalid = 0; mac_*_tdata = 0; m_axis_tvalid = 0; m_axis_tdata = 0; m_axis_tuser = 0.
REQ-033 Reset mid-vector SHALL discard partial acc and count; no result is emitted for the aborted vector.

Verification
REQ-034 Pairs (4,8),(2,2),(255,255,tlast), reference MAC, m_axis_tready = 1 -> m_axis_tdata = 16265 (8+1+16256), tuser = {0, 3}; mac_*_tvalid high exactly 3 cycles.
REQ-035 Single pair (3,3,tlast) -> tdata = 2, tuser = {0, 1}; handshake-to-m_axis_tvalid = 3 cycles.
REQ-036 Backpressure: m_axis_tready low for 10 cycles during OUTPUT -> tvalid, tdata and tuser stable for 10 cycles; s_axis_tready stays 0; one transfer on release.
REQ-037 Timeout: MAC stub never asserts result after pair (1,4) -> 15 WAIT cycles, then tvalid with tdata = 0, tuser = {1, 0}; the next vector starts with err = 0.
REQ-038 Reset asserted in WAIT of the second pair, then a new vector (8,8,tlast) -> tdata = 16, tuser = {0, 1}; no result for the aborted vector.
REQ-039 Spurious mac_result_tvalid in ACCEPT with data 0xDEAD -> acc unchanged; the following vector (2,2,tlast) yields 1.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
// Streams unsigned 8-bit operand pairs into an external MAC one at a time.
// The MAC accumulator input is fed from the running accumulator. When the
// final pair of a vector (tlast) comes back, the accumulated dot product is
// emitted on the output stream. A MAC result that never arrives is bounded
// by TIMEOUT wait cycles. In that case the partial sum is emitted with the
// timeout_err flag set.
//
// Ports
//   aclk, aresetn            clock; synchronous active-low reset
//   s_axis_tvalid/tready     operand pair handshake
//   s_axis_tdata[15:0]       {b[7:0], a[7:0]}
//   s_axis_tlast             final pair of the current dot product
//   mac_a/b/c_tvalid         MAC operand valids (one cycle per pair)
//   mac_a/b_tdata[7:0]       MAC multiplicands
//   mac_c_tdata[31:0]        MAC accumulator input
//   mac_result_tvalid/tdata  MAC result, one cycle after the operands
//   m_axis_tvalid/tready     dot-product result handshake
//   m_axis_tdata[31:0]       accumulated dot product
//   m_axis_tuser[16:0]       {timeout_err, element_count[15:0]}
module mac_dot_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [15:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   output logic        mac_a_tvalid,
   output logic        mac_b_tvalid,
   output logic        mac_c_tvalid,
   output logic [7:0]  mac_a_tdata,
   output logic [7:0]  mac_b_tdata,
   output logic [31:0] mac_c_tdata,
   input  logic        mac_result_tvalid,
   input  logic [31:0] mac_result_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic [16:0] m_axis_tuser
);

   localparam logic [1:0] ST_ACCEPT = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_OUTPUT = 2'd3;

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [1:0]    state_reg, state_next;
   logic [31:0]   acc_reg, acc_next;
   logic [15:0]   count_reg, count_next;
   logic          err_reg, err_next;
   logic [CW-1:0] wait_cnt_reg;
   logic          tlast_reg;
   logic          s_ready_reg;
   logic          mac_valid_reg;
   logic [7:0]    mac_a_reg, mac_b_reg;
   logic [31:0]   mac_c_reg;
   logic          m_valid_reg;
   logic [31:0]   m_data_reg;
   logic [16:0]   m_user_reg;

   logic s_hs, m_hs, result_hit, timed_out;

   // s_ready_reg is only ever high in ACCEPT, so it alone qualifies the input
   // handshake; likewise m_valid_reg is only high in OUTPUT.
   assign s_hs       = s_ready_reg & s_axis_tvalid;
   assign m_hs       = m_valid_reg & m_axis_tready;
   assign result_hit = (state_reg == ST_WAIT) & mac_result_tvalid;
   // A result arriving in the last allowed wait cycle still wins over timeout.
   assign timed_out  = (state_reg == ST_WAIT) & ~mac_result_tvalid &
                       (wait_cnt_reg == CW'(TIMEOUT - 1));

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      count_next = count_reg;
      err_next   = err_reg;
      case (state_reg)
         ST_ACCEPT: if (s_hs) state_next = ST_ISSUE;
         ST_ISSUE:  state_next = ST_WAIT;
         ST_WAIT: begin
            if (result_hit) begin
               acc_next   = mac_result_tdata;
               count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
               state_next = tlast_reg ? ST_OUTPUT : ST_ACCEPT;
            end else if (timed_out) begin
               err_next   = 1'b1;
               state_next = ST_OUTPUT;
            end
         end
         default: begin
            if (m_hs) begin
               acc_next   = '0;
               count_next = '0;
               err_next   = 1'b0;
               state_next = ST_ACCEPT;
            end
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_reg     <= ST_ACCEPT;
         acc_reg       <= '0;
         count_reg     <= '0;
         err_reg       <= 1'b0;
         wait_cnt_reg  <= '0;
         tlast_reg     <= 1'b0;
         s_ready_reg   <= 1'b0;
         mac_valid_reg <= 1'b0;
         mac_a_reg     <= '0;
         mac_b_reg     <= '0;
         mac_c_reg     <= '0;
         m_valid_reg   <= 1'b0;
         m_data_reg    <= '0;
         m_user_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         count_reg     <= count_next;
         err_reg       <= err_next;
         s_ready_reg   <= (state_next == ST_ACCEPT);
         mac_valid_reg <= (state_next == ST_ISSUE);
         m_valid_reg   <= (state_next == ST_OUTPUT);

         if (s_hs) begin
            mac_a_reg <= s_axis_tdata[7:0];
            mac_b_reg <= s_axis_tdata[15:8];
            mac_c_reg <= acc_reg;
            tlast_reg <= s_axis_tlast;
         end

         if (state_reg == ST_ISSUE)
            wait_cnt_reg <= '0;
         else if (state_reg == ST_WAIT)
            wait_cnt_reg <= wait_cnt_reg + CW'(1);

         // Output payload is captured once on entry to OUTPUT and then held
         // for as long as the consumer stalls.
         if (state_reg != ST_OUTPUT && state_next == ST_OUTPUT) begin
            m_data_reg <= acc_next;
            m_user_reg <= {err_next, count_next};
         end
      end
   end

   assign s_axis_tready = s_ready_reg;
   assign mac_a_tvalid  = mac_valid_reg;
   assign mac_b_tvalid  = mac_valid_reg;
   assign mac_c_tvalid  = mac_valid_reg;
   assign mac_a_tdata   = mac_a_reg;
   assign mac_b_tdata   = mac_b_reg;
   assign mac_c_tdata   = mac_c_reg;
   assign m_axis_tvalid = m_valid_reg;
   assign m_axis_tdata  = m_data_reg;
   assign m_axis_tuser  = m_user_reg;

endmodule
